// File: rtl/coincidence_recorder.sv
// coincidence_recorder: refClk phase histogrammer and heartbeat aligner.
// Build option: define COINCIDENCE_RECORDER_STATUS_EN to expose pending/toggle in sysCsr[30:29].
//
// Ports:
//   sysClk             in  1   only clock
//   sysReset           in  1   synchronous active-high reset
//   sysCsrStrobe       in  1   CSR write strobe
//   sysGPIO_OUT        in  32  CSR write data
//   sysCsr             out 32  {busy, status[1:0], 0.., bin readback}
//   sysRealignToggle   out 1   realign request toggle
//   sysRealignToggleIn in  1   realign event toggle (may be looped back)
//   refClk             in  CHANNEL_COUNT sampled reference inputs
//   txHeartbeatStrobe  out 1   one-clock heartbeat pulse
//
// CSR write decode (first match wins):
//   bit31 start acquisition, bit30 load phase offset,
//   bit29 flip realign toggle, else readout select {chan[28:24], addr[23:0]}.
module coincidence_recorder #(
    parameter int CHANNEL_COUNT                = 2,
    parameter int CYCLES_PER_ACQUISITION       = 7,
    parameter int SAMPLE_CLKS_PER_COINCIDENCE  = 400,
    parameter int INPUT_CYCLES_PER_COINCIDENCE = 399,
    parameter int TX_CLK_PER_HEARTBEAT         = 1197,
    localparam int DATA_WIDTH = $clog2(CYCLES_PER_ACQUISITION + 1)
) (
    input  logic                     sysClk,
    input  logic                     sysReset,
    input  logic                     sysCsrStrobe,
    input  logic [31:0]              sysGPIO_OUT,
    output logic [31:0]              sysCsr,
    output logic                     sysRealignToggle,
    input  logic                     sysRealignToggleIn,
    input  logic [CHANNEL_COUNT-1:0] refClk,
    output logic                     txHeartbeatStrobe
);

    localparam int LP_S  = SAMPLE_CLKS_PER_COINCIDENCE;
    localparam int LP_PW = (LP_S > 1) ? $clog2(LP_S) : 1;
    localparam int LP_TW = (TX_CLK_PER_HEARTBEAT > 1) ?
                           $clog2(TX_CLK_PER_HEARTBEAT) : 1;
    localparam int LP_CW = (CYCLES_PER_ACQUISITION > 1) ?
                           $clog2(CYCLES_PER_ACQUISITION) : 1;
    localparam int LP_HW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
    localparam int LP_PAD = 29 - DATA_WIDTH;

    localparam logic [LP_PW-1:0] LP_PH_LAST  = LP_PW'(LP_S - 1);
    localparam logic [LP_PW-1:0] LP_PH_ONE   = LP_PW'(1);
    localparam logic [LP_TW-1:0] LP_TX_LAST  = LP_TW'(TX_CLK_PER_HEARTBEAT - 1);
    localparam logic [LP_TW-1:0] LP_TX_ONE   = LP_TW'(1);
    localparam logic [LP_CW-1:0] LP_CYC_LAST = LP_CW'(CYCLES_PER_ACQUISITION - 1);
    localparam logic [LP_CW-1:0] LP_CYC_ONE  = LP_CW'(1);
    localparam logic [23:0]      LP_S24      = 24'(LP_S);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LP_PW-1:0]      r_phase;
    logic [LP_PW-1:0]      r_offset;
    logic [LP_CW-1:0]      r_cyc;
    logic [LP_TW-1:0]      r_tx;
    logic                  r_pending;
    logic                  r_toggle;
    logic                  r_tin_q;
    logic [4:0]            r_rd_chan;
    logic [23:0]           r_rd_addr;
    logic [31:0]           r_csr;
    logic [DATA_WIDTH-1:0] r_ram [CHANNEL_COUNT][LP_S];

    logic                  w_ph_last;
    logic                  w_ph_zero;
    logic                  w_cyc_last;
    logic                  w_wr_start;
    logic                  w_wr_off;
    logic                  w_wr_tog;
    logic                  w_wr_sel;
    logic                  w_sample;
    logic                  w_first;
    logic                  w_busy_nxt;
    logic                  w_tin_chg;
    logic                  w_align;
    logic [LP_TW-1:0]      w_tx_cur;
    logic [LP_PW-1:0]      w_off_mod;
    logic                  w_rd_hit;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]            w_stat;
    logic [31:0]           w_unused_info;

    // Informational parameter, kept visible for documentation only.
    assign w_unused_info = 32'(INPUT_CYCLES_PER_COINCIDENCE);

    assign w_ph_last  = (r_phase == LP_PH_LAST);
    assign w_ph_zero  = (r_phase == '0);
    assign w_cyc_last = (r_cyc == LP_CYC_LAST);

    // CSR decode: a start request matches bit31 even when it is ignored.
    assign w_wr_start = sysCsrStrobe & sysGPIO_OUT[31];
    assign w_wr_off   = sysCsrStrobe & ~sysGPIO_OUT[31] & sysGPIO_OUT[30];
    assign w_wr_tog   = sysCsrStrobe & ~sysGPIO_OUT[31] & ~sysGPIO_OUT[30]
                      & sysGPIO_OUT[29];
    assign w_wr_sel   = sysCsrStrobe & ~(|sysGPIO_OUT[31:29]);
    assign w_off_mod  = LP_PW'(sysGPIO_OUT[23:0] % LP_S24);

    // Realign: edge on the incoming toggle arms a request, which fires
    // when the sample counter reaches the programmed offset.
    assign w_tin_chg = sysRealignToggleIn ^ r_tin_q;
    assign w_align   = r_pending & (r_phase == r_offset);

    // Forcing the count to zero in the aligning clock itself makes the
    // strobe land on phase==offset and merges with a natural wrap.
    assign w_tx_cur          = w_align ? '0 : r_tx;
    assign txHeartbeatStrobe = (w_tx_cur == '0);
    assign sysRealignToggle  = r_toggle;
    assign sysCsr            = r_csr;

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            r_phase   <= '0;
            r_tx      <= LP_TX_ONE;
            r_pending <= 1'b0;
            r_tin_q   <= sysRealignToggleIn;
        end else begin
            r_phase   <= w_ph_last ? '0 : r_phase + LP_PH_ONE;
            r_tx      <= (w_tx_cur == LP_TX_LAST) ? '0 : w_tx_cur + LP_TX_ONE;
            r_pending <= w_tin_chg | (r_pending & ~w_align);
            r_tin_q   <= sysRealignToggleIn;
        end
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            r_offset  <= '0;
            r_toggle  <= 1'b0;
            r_rd_chan <= '0;
            r_rd_addr <= '0;
        end else begin
            if (w_wr_off) begin
                r_offset <= w_off_mod;
            end
            if (w_wr_tog) begin
                r_toggle <= ~r_toggle;
            end
            if (w_wr_sel) begin
                r_rd_chan <= sysGPIO_OUT[28:24];
                r_rd_addr <= sysGPIO_OUT[23:0];
            end
        end
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Acquisition sequencing. The first sample is taken in WAIT on the
    // phase-zero clock so the run covers exactly whole periods.
    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_first     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_wr_start) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_ph_zero) begin
                    w_sample    = 1'b1;
                    w_first     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_sample = 1'b1;
                w_first  = (r_cyc == '0);
                if (w_ph_last && w_cyc_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            r_cyc <= '0;
        end else if (r_state == ST_WAIT) begin
            r_cyc <= '0;
        end else if ((r_state == ST_RUN) && w_ph_last) begin
            r_cyc <= r_cyc + LP_CYC_ONE;
        end
    end

    // Histogram RAM: not reset. The first period overwrites stale data.
    always_ff @(posedge sysClk) begin
        if (w_sample && !sysReset) begin
            for (int c = 0; c < CHANNEL_COUNT; c++) begin
                if (w_first) begin
                    r_ram[c][r_phase] <= DATA_WIDTH'(refClk[c]);
                end else begin
                    r_ram[c][r_phase] <= r_ram[c][r_phase]
                                       + DATA_WIDTH'(refClk[c]);
                end
            end
        end
    end

    assign w_rd_hit = (32'(r_rd_chan) < 32'(CHANNEL_COUNT))
                    && (32'(r_rd_addr) < 32'(LP_S));

    always_comb begin
        w_rd_data = '0;
        if (w_rd_hit) begin
            w_rd_data = r_ram[r_rd_chan[LP_HW-1:0]][r_rd_addr[LP_PW-1:0]];
        end
    end

`ifdef COINCIDENCE_RECORDER_STATUS_EN
    assign w_stat = {r_pending, r_toggle};
`else
    assign w_stat = 2'b00;
`endif

    // Busy is taken from the next state so it shows one clock after start.
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            r_csr <= '0;
        end else begin
            r_csr <= {w_busy_nxt, w_stat, {LP_PAD{1'b0}}, w_rd_data};
        end
    end

endmodule

// File: tb/tb_coincidence_recorder.sv
// Self-checking bench for coincidence_recorder.
// Reference model tracks phase, acquisition windows and bin sums.
module tb_coincidence_recorder;

    localparam int S = 400;
    localparam int C = 7;
    localparam int T = 1197;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic [31:0] gpio = '0;
    logic [31:0] csr;
    logic        tog;
    logic        tin;
    logic        hb;
    logic [1:0]  refclk = 2'b00;

    assign tin = tog;

    always #5 clk = ~clk;

    coincidence_recorder dut (
        .sysClk             (clk),
        .sysReset           (rst),
        .sysCsrStrobe       (stb),
        .sysGPIO_OUT        (gpio),
        .sysCsr             (csr),
        .sysRealignToggle   (tog),
        .sysRealignToggleIn (tin),
        .refClk             (refclk),
        .txHeartbeatStrobe  (hb)
    );

    int n_chk = 0;
    int n_fail = 0;
    int mphase = 0;
    bit mwait = 1'b0;
    bit mrun = 1'b0;
    int mn = 0;
    int exp_bin [2][S];
    int mode = 0;
    bit mtog = 1'b0;

    // Model: phase = clocks since reset mod S; an accepted start samples
    // C*S consecutive clocks beginning at the next phase-zero clock.
    always @(posedge clk) begin
        bit was_busy;
        if (rst) begin
            mphase = 0;
            mwait = 1'b0;
            mrun = 1'b0;
        end else begin
            was_busy = mwait | mrun;
            if (mwait && mphase == 0) begin
                mwait = 1'b0;
                mrun = 1'b1;
                mn = 0;
            end
            if (mrun) begin
                for (int c = 0; c < 2; c++) begin
                    if (mn < S) exp_bin[c][mphase] = int'(refclk[c]);
                    else exp_bin[c][mphase] += int'(refclk[c]);
                end
                mn++;
                if (mn == C * S) mrun = 1'b0;
            end
            if (stb && gpio[31] && !was_busy) mwait = 1'b1;
            mphase = (mphase + 1) % S;
        end
    end

    always @(negedge clk) begin
        int np;
        np = mrun ? mn / S : 0;
        case (mode)
            1: refclk = {1'b0, (mphase >= 100 && mphase < 300)};
            2: refclk = {1'b1, ((np % 2) == 0)};
            3: refclk = 2'($urandom);
            default: refclk = 2'b00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic csr_write(input logic [31:0] w);
        @(negedge clk);
        stb = 1'b1;
        gpio = w;
        @(negedge clk);
        stb = 1'b0;
        gpio = '0;
    endtask

    task automatic rd(input int ch, input int a, output logic [31:0] v);
        csr_write({3'b000, 5'(ch), 24'(a)});
        @(negedge clk);
        v = csr;
    endtask

    task automatic run_acq(input string tag, input bit second);
        int n;
        csr_write(32'h8000_0000);
        chk({tag, "_busy_on"}, 32'(csr[31]), 1);
        n = 0;
        while (csr[31] && n < 3400) begin
            @(negedge clk);
            n++;
            if (second && n == 1000) begin
                csr_write(32'h8000_0000);
                n += 2;
                chk({tag, "_busy_2nd"}, 32'(csr[31]), 1);
            end
        end
        chk({tag, "_busy_len"}, 32'(n >= C * S && n <= 3200), 1);
        chk({tag, "_busy_model"}, 32'(csr[31]), 32'(mwait | mrun));
    endtask

    task automatic dump(input string tag, input int kind);
        logic [31:0] v;
        int e;
        for (int ch = 0; ch < 2; ch++) begin
            for (int a = 0; a < S; a++) begin
                rd(ch, a, v);
                case (kind)
                    0: e = (ch == 0 && a >= 100 && a < 300) ? C : 0;
                    1: e = (ch == 0) ? 4 : C;
                    default: e = exp_bin[ch][a];
                endcase
                chk($sformatf("%s_c%0d_a%0d", tag, ch, a),
                    v & 32'h9FFF_FFFF, 32'(e));
            end
        end
    endtask

    task automatic realign(input string tag, input logic [31:0] offw,
                           input int ph);
        int n;
        csr_write(offw);
        n = 0;
        while (!hb && n < 1300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_sync"}, 32'(hb), 1);
        csr_write(32'h2000_0000);
        mtog = ~mtog;
        chk({tag, "_tog"}, 32'(tog), 32'(mtog));
        n = 0;
        while (!hb && n < 420) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(hb && n <= 402), 1);
        chk({tag, "_phase"}, 32'(mphase), 32'(ph));
`ifdef COINCIDENCE_RECORDER_STATUS_EN
        chk({tag, "_stat"}, 32'(csr[29]), 32'(mtog));
`else
        chk({tag, "_stat"}, 32'(csr[30:29]), 0);
`endif
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!hb && n < 1300);
        chk({tag, "_gap"}, 32'(n), T);
        chk({tag, "_phase2"}, 32'(mphase), 32'((ph + T) % S));
    endtask

    initial begin
        logic [31:0] v;
        int ch;
        int a;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_csr", csr, 0);
        chk("rst_hb", 32'(hb), 0);
        chk("rst_tog", 32'(tog), 0);
        for (int k = 0; k < 2400; k++) begin
            if (k == 50) chk("idle_csr", csr, 0);
            chk("hb_idle", 32'(hb), 32'((k % T) == T - 1));
            @(negedge clk);
        end

        mode = 1;
        run_acq("acq_win", 1'b0);
        dump("win", 0);

        mode = 2;
        run_acq("acq_alt", 1'b1);
        dump("alt", 1);

        mode = 3;
        run_acq("acq_rnd", 1'b0);
        mode = 0;
        dump("rnd", 2);

        csr_write(32'h0100_012C);
        @(negedge clk);
        chk("rd_c1_a300", 32'(csr[2:0]), 32'(exp_bin[1][300]));
        csr_write(32'h0000_0190);
        @(negedge clk);
        chk("rd_addr_oor", csr & 32'h9FFF_FFFF, 0);
        csr_write(32'h0200_0000);
        @(negedge clk);
        chk("rd_chan_oor", csr & 32'h9FFF_FFFF, 0);

        realign("ra95", 32'h4000_005F, 95);
        realign("ra101", 32'h4000_01F5, 101);

        mode = 3;
        csr_write(32'h8000_0000);
        repeat (500) @(negedge clk);
        chk("mid_busy", 32'(csr[31]), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_csr", csr, 0);
        chk("mid_rst_hb", 32'(hb), 0);
        chk("mid_rst_tog", 32'(tog), 0);
        rst = 1'b0;
        mtog = 1'b0;
        mode = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("post_rst_hb", 32'(hb), 0);
            chk("post_rst_busy", 32'(csr[31]), 0);
        end
        for (int k = 0; k < 6; k++) begin
            ch = int'($urandom_range(0, 1));
            a = int'($urandom_range(0, S - 1));
            rd(ch, a, v);
            chk($sformatf("partial_c%0d_a%0d", ch, a),
                v & 32'h9FFF_FFFF, 32'(exp_bin[ch][a]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
